serial_comparator_ctrl: RTL and testbench
=========================================

// Module: serial_comparator_ctrl
// PURPOSE
//  Sequences one external comparator_1bit across two WIDTH-bit operands, MSB first, to give an N-bit
//  magnitude compare using a single 1-bit comparator. Operands are latched on a start/done handshake.
//  The controller drives the comparator bit inputs, samples its three outputs each cycle, and
//  registers the final smaller/equal/greater result.
//  Sits between a requesting datapath and the shared comparator_1bit instance.
// PARAMETERS
//  WIDTH      8   operand width in bits; legal range 1..32
// PORTS
//  clk          in   1      rising-edge clock; sole clock domain
//  reset        in   1      asynchronous, active-high reset
//  start        in   1      request; sampled only in IDLE
//  a_in         in   WIDTH  operand A; latched on accepted start
//  b_in         in   WIDTH  operand B; latched on accepted start
//  cmp_a        out  1      bit to comparator .a (= a_reg[idx] in COMPARE, else 0)
//  cmp_b        out  1      bit to comparator .b (= b_reg[idx] in COMPARE, else 0)
//  cmp_smaller  in   1      comparator .smaller
//  cmp_equal    in   1      comparator .equal
//  cmp_greater  in   1      comparator .greater
//  busy         out  1      high while in COMPARE
//  done         out  1      one-cycle pulse; result is valid from this cycle onward
//  smaller      out  1      registered result, A < B
//  equal        out  1      registered result, A == B
//  greater      out  1      registered result, A > B
//  cmp_err      out  1      sticky: comparator outputs were not one-hot during COMPARE
// BEHAVIOUR
//  - Reset (async, any state): state=IDLE; idx=WIDTH-1; busy, done, smaller, equal, greater,
//    cmp_err = 0; operand and decided registers = 0. Reset mid-COMPARE aborts the operation
//    with no done pulse.
//  - FSM: IDLE -> COMPARE on start. COMPARE -> IDLE on the finishing edge.
//  - IDLE: at edge E0 with start=1: latch a_in/b_in, idx<=WIDTH-1, clear decided, go to COMPARE.
//    smaller/equal/greater keep their last values until the accepted start; they clear at E0.
//  - COMPARE: every cycle, cmp_a/cmp_b = operand bit idx (combinational from registers). On each edge:
//    - Sample the cmp_* outputs.
//    - If not one-hot: cmp_err<=1, and treat the bit as equal.
//    - First non-equal bit: latch smaller/greater, set decided.
//    - idx==0, or (decided && EARLY_EXIT_EN): finish. Registers equal<=!decided, done<=1 for
//      one cycle, go to IDLE.
//    - Otherwise idx<=idx-1.
//  - start while busy: ignored; operands are not re-latched.
//  - start high in the done cycle: accepted, because the state is already IDLE.
//    Back-to-back ops are therefore 1 idle cycle apart minimum.
//  - Results are exactly one-hot after done. The all-zero value occurs only after reset or
//    during busy.
//  - WIDTH=1: a single COMPARE cycle.
//  - cmp_err clears only on reset.
// CONFIGURATION
//  EARLY_EXIT_EN defined:
//    - finish on the first differing bit k (bit index, MSB=WIDTH-1).
//    - done at edge E0+(WIDTH-k); equal operands take E0+WIDTH.
//  EARLY_EXIT_EN undefined:
//    - constant time: done always at E0+WIDTH.
//    - bits after the first difference are still driven and checked for cmp_err, but do not
//      change the result.
// TESTING (WIDTH=8, real comparator_1bit unless noted; E0 = start edge)
//  1. a=8'hA5, b=8'hA5 -> done at E0+8; equal=1, smaller=0, greater=0; busy high 8 cycles.
//  2. a=8'h80, b=8'h7F -> greater=1. done at E0+1 with EARLY_EXIT_EN, E0+8 without.
//  3. a=8'h12, b=8'h13 -> smaller=1; done at E0+8 in both configurations.
//  4. a=8'h01, b=8'h02 accepted, then start held with a=8'hFF, b=8'h00 while busy -> the second
//     request is ignored; the result is smaller=1. The next start in the done cycle is accepted.
//  5. reset pulse mid-COMPARE (idx=4) -> all outputs 0 immediately, no done. After release,
//     a=8'h03, b=8'h03 -> equal=1 at E0+8.
//  6. Stub comparator drives equal=1 and greater=1 together -> cmp_err=1 and stays 1 across
//     later ops until reset; the result is treated as equal for that bit.

Source files
------------

// File: rtl/serial_comparator_ctrl.sv
// Serial MSB-first magnitude comparator controller driving one shared comparator_1bit.
// Optional feature macro: EARLY_EXIT_EN (finish on the first differing bit).
module serial_comparator_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             cmp_a,
    output logic             cmp_b,
    input  logic             cmp_smaller,
    input  logic             cmp_equal,
    input  logic             cmp_greater,
    output logic             busy,
    output logic             done,
    output logic             smaller,
    output logic             equal,
    output logic             greater,
    output logic             cmp_err
);

    localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [0:0] ST_IDLE    = 1'b0;
    localparam logic [0:0] ST_COMPARE = 1'b1;

`ifdef EARLY_EXIT_EN
    localparam logic EARLY_EXIT = 1'b1;
`else
    localparam logic EARLY_EXIT = 1'b0;
`endif

    function automatic logic is_one_hot3(input logic s, input logic e, input logic g);
        return (s ^ e ^ g) & ~(s & e & g);
    endfunction

    logic [0:0]       r_state;
    logic [IDX_W-1:0] r_idx;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_decided;
    logic             r_done;
    logic             r_smaller;
    logic             r_equal;
    logic             r_greater;
    logic             r_err;

    logic w_one_hot;
    logic w_bit_lt;
    logic w_bit_gt;
    logic w_decided_next;
    logic w_finish;
    logic w_busy;

    assign w_busy = (r_state == ST_COMPARE);

    // Bit drive and per-bit decision; a non-one-hot comparator answer counts as "equal".
    always_comb begin
        cmp_a          = 1'b0;
        cmp_b          = 1'b0;
        w_one_hot      = is_one_hot3(cmp_smaller, cmp_equal, cmp_greater);
        w_bit_lt       = w_one_hot & cmp_smaller;
        w_bit_gt       = w_one_hot & cmp_greater;
        w_decided_next = r_decided | w_bit_lt | w_bit_gt;
        w_finish       = (r_idx == '0) || (w_decided_next && EARLY_EXIT);
        if (w_busy) begin
            cmp_a = r_a[r_idx];
            cmp_b = r_b[r_idx];
        end else begin
            cmp_a = 1'b0;
            cmp_b = 1'b0;
        end
    end

    // Controller FSM, operand latch and result registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_idx     <= IDX_W'(WIDTH - 1);
            r_a       <= '0;
            r_b       <= '0;
            r_decided <= 1'b0;
            r_done    <= 1'b0;
            r_smaller <= 1'b0;
            r_equal   <= 1'b0;
            r_greater <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_a       <= a_in;
                        r_b       <= b_in;
                        r_idx     <= IDX_W'(WIDTH - 1);
                        r_decided <= 1'b0;
                        r_smaller <= 1'b0;
                        r_equal   <= 1'b0;
                        r_greater <= 1'b0;
                        r_state   <= ST_COMPARE;
                    end
                end
                ST_COMPARE: begin
                    if (!w_one_hot) begin
                        r_err <= 1'b1;
                    end
                    // Only the first differing bit sets the result; later bits are still checked.
                    if (!r_decided && (w_bit_lt || w_bit_gt)) begin
                        r_smaller <= w_bit_lt;
                        r_greater <= w_bit_gt;
                        r_decided <= 1'b1;
                    end
                    if (w_finish) begin
                        r_equal <= ~w_decided_next;
                        r_done  <= 1'b1;
                        r_state <= ST_IDLE;
                    end else begin
                        r_idx <= r_idx - IDX_W'(1);
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign busy    = w_busy;
    assign done    = r_done;
    assign smaller = r_smaller;
    assign equal   = r_equal;
    assign greater = r_greater;
    assign cmp_err = r_err;

endmodule

// File: tb/tb_serial_comparator_ctrl.sv
// Directed self-checking bench for serial_comparator_ctrl (WIDTH=8) with a behavioural
// comparator_1bit that can be switched to a faulty stub driving equal and greater together.
module tb_serial_comparator_ctrl;

`ifdef EARLY_EXIT_EN
    localparam bit EE = 1'b1;
`else
    localparam bit EE = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [7:0] a_in;
    logic [7:0] b_in;
    logic       cmp_a, cmp_b;
    logic       cmp_smaller, cmp_equal, cmp_greater;
    logic       busy, done, smaller, equal, greater, cmp_err;
    logic       stub_mode;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    // Reference 1-bit comparator, or a faulty non-one-hot stub.
    always_comb begin
        if (stub_mode) begin
            cmp_smaller = 1'b0;
            cmp_equal   = 1'b1;
            cmp_greater = 1'b1;
        end else begin
            cmp_smaller = ~cmp_a & cmp_b;
            cmp_equal   = ~(cmp_a ^ cmp_b);
            cmp_greater = cmp_a & ~cmp_b;
        end
    end

    serial_comparator_ctrl #(.WIDTH(8)) dut (
        .clk(clk), .reset(reset), .start(start), .a_in(a_in), .b_in(b_in),
        .cmp_a(cmp_a), .cmp_b(cmp_b),
        .cmp_smaller(cmp_smaller), .cmp_equal(cmp_equal), .cmp_greater(cmp_greater),
        .busy(busy), .done(done), .smaller(smaller), .equal(equal), .greater(greater),
        .cmp_err(cmp_err)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Waits for done (bounded); lat counts edges after E0, nbusy counts busy samples.
    task automatic wait_done(input string tag, output int lat, output int nbusy);
        bit found = 1'b0;
        lat   = 0;
        nbusy = 1;
        for (int i = 0; i < 20; i++) begin
            if (!found) begin
                @(posedge clk); #1;
                lat++;
                if (done) found = 1'b1;
                else if (busy) nbusy++;
            end
        end
        if (!found) check_eq({tag, "_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                          input int lat_early, input int lat_full, input logic [2:0] exp_res);
        int lat, nbusy, exp_lat;
        exp_lat = EE ? lat_early : lat_full;
        @(negedge clk);
        start = 1'b1; a_in = a; b_in = b;
        @(posedge clk); #1;
        start = 1'b0;
        check_eq({tag, "_busy"}, 32'(busy), 32'd1);
        check_eq({tag, "_cleared"}, 32'({smaller, equal, greater}), 32'd0);
        check_eq({tag, "_cmp_ab"}, 32'({cmp_a, cmp_b}), 32'({a[7], b[7]}));
        wait_done(tag, lat, nbusy);
        check_eq({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        check_eq({tag, "_busy_cycles"}, 32'(nbusy), 32'(exp_lat));
        check_eq({tag, "_result"}, 32'({smaller, equal, greater}), 32'(exp_res));
        @(posedge clk); #1;
        check_eq({tag, "_done_pulse"}, 32'(done), 32'd0);
        check_eq({tag, "_hold"}, 32'({smaller, equal, greater}), 32'(exp_res));
    endtask

    initial begin
        int lat, nbusy, ndone;
        reset = 1'b1; start = 1'b0; a_in = 8'h00; b_in = 8'h00; stub_mode = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("reset_outs", 32'({busy, done, smaller, equal, greater, cmp_err}), 32'd0);
        @(negedge clk); reset = 1'b0;

        // Result encoding {smaller, equal, greater}
        run_op("t1_eq",  8'hA5, 8'hA5, 8, 8, 3'b010);
        run_op("t2_gt",  8'h80, 8'h7F, 1, 8, 3'b001);
        run_op("t3_lt",  8'h12, 8'h13, 8, 8, 3'b100);

        // Request while busy is ignored; start held into the done cycle is accepted.
        @(negedge clk);
        start = 1'b1; a_in = 8'h01; b_in = 8'h02;
        @(posedge clk); #1;
        a_in = 8'hFF; b_in = 8'h00;
        wait_done("t4a", lat, nbusy);
        check_eq("t4a_latency", 32'(lat), EE ? 32'd7 : 32'd8);
        check_eq("t4a_result", 32'({smaller, equal, greater}), 32'b100);
        @(posedge clk); #1;
        start = 1'b0;
        check_eq("t4b_accept", 32'(busy), 32'd1);
        wait_done("t4b", lat, nbusy);
        check_eq("t4b_latency", 32'(lat), EE ? 32'd1 : 32'd8);
        check_eq("t4b_result", 32'({smaller, equal, greater}), 32'b001);

        // Reset mid-COMPARE at idx=4
        @(negedge clk);
        start = 1'b1; a_in = 8'h55; b_in = 8'h55;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        check_eq("t5_pre_busy", 32'(busy), 32'd1);
        check_eq("t5_idx4_cmp_ab", 32'({cmp_a, cmp_b}), 32'b11);
        reset = 1'b1;
        #1;
        check_eq("t5_async_clear", 32'({busy, done, smaller, equal, greater, cmp_err}), 32'd0);
        @(negedge clk); reset = 1'b0;
        ndone = 0;
        repeat (10) begin @(posedge clk); #1; if (done) ndone++; end
        check_eq("t5_no_done", 32'(ndone), 32'd0);
        run_op("t5_eq",  8'h03, 8'h03, 8, 8, 3'b010);
        check_eq("t6_err_before", 32'(cmp_err), 32'd0);

        // Non-one-hot comparator answers
        stub_mode = 1'b1;
        run_op("t6_stub", 8'h0F, 8'hF0, 8, 8, 3'b010);
        check_eq("t6_err_set", 32'(cmp_err), 32'd1);
        stub_mode = 1'b0;
        run_op("t6_after", 8'h80, 8'h7F, 1, 8, 3'b001);
        check_eq("t6_err_sticky", 32'(cmp_err), 32'd1);
        @(negedge clk); reset = 1'b1;
        @(negedge clk); reset = 1'b0;
        check_eq("t6_err_cleared", 32'(cmp_err), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
